mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between NCORES core pipelines.
- Each core presents one load or store request at a time; the arbiter grants one request per cycle, round-robin.
- It drives the memory command, tracks in-flight reads through the fixed memory read latency, and returns read data to the requesting core only.
- Sits between the per-core select stages and the data memory; replaces the daisy-chained ld/st enable bus.

Parameters:
- NCORES, 4, number of requesting cores (>=2).
- READ_LAT, 2, cycles from mem_en (read) to mem_rdata valid (>=1).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NCORES  per-core request pending.
- req_we  input  NCORES  per-core 1=store, 0=load.
- req_addr  input  NCORES*AW  per-core address, core i at [i*AW +: AW].
- req_wdata  input  NCORES*DW  per-core store data, same packing.
- req_gnt  output  NCORES  one-hot grant, combinational, same cycle as the accepted request.
- rsp_valid  output  NCORES  one-hot load-data-valid.
- rsp_data  output  DW  load data, shared by all cores.
- mem_en  output  1  memory command valid (registered).
- mem_we  output  1  memory write enable (registered).
- mem_addr  output  AW  registered.
- mem_wdata  output  DW  registered.
- mem_rdata  input  DW  read data, valid READ_LAT cycles after a read command.
- busy  output  1  any read in flight or command pending.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_data=0 when idle.
  - Round-robin pointer=0; read-tag pipeline cleared.
  - req_gnt=0 while rst_n=0.
  - Reset mid-operation drops all in-flight reads: no rsp_valid is issued for them after reset release.
- Handshake:
  - A core holds req_valid and its we/addr/wdata stable until req_gnt[i]=1 for one cycle.
  - The core may present a new request the cycle after the grant.
  - Grant fires in the same cycle the request is seen; no request waits while the port is free.
- Arbitration:
  - At most one grant per cycle.
  - Search starts at the pointer index and wraps modulo NCORES; the first core with req_valid wins.
  - On grant to core g, pointer <= (g+1) mod NCORES.
  - No grant leaves the pointer unchanged.
  - No requests gives req_gnt=0.
  - A single requester is granted every cycle it requests.
- Command stage:
  - The granted request is registered onto mem_* in the next cycle (cycle N grant -> cycle N+1 mem_en=1).
  - mem_en=0 in any cycle following a no-grant cycle.
- Read tracking:
  - A read command in cycle C pushes {valid, core index} into a READ_LAT-deep shift register.
  - In cycle C+READ_LAT: rsp_valid[idx]=1 and rsp_data=mem_rdata (combinational pass-through).
  - Otherwise rsp_valid=0 and rsp_data=0.
  - Load latency seen by a core is grant cycle + 1 + READ_LAT.
  - Stores produce no response.
- Ordering:
  - Memory commands are issued strictly in grant order.
  - A load granted after a store to the same address returns the stored data (memory is in-order, write-first).
- Simultaneous events:
  - A core may be granted a new request in the same cycle it receives rsp_valid for an earlier load.
  - Responses from back-to-back grants arrive in consecutive cycles, one per cycle.
- busy = mem_en | any valid bit in the read-tag pipeline.
- Invalid inputs: req_we and req_addr are ignored when req_valid=0.

Optional Feature:
- Macro MEM_ARB_STORE_FIRST_EN.
- Defined:
  - Any pending store beats every pending load.
  - Round-robin search runs over storing cores only; loads are considered only when no store is pending.
  - The pointer updates on every grant as normal.
  - Purpose: write-back of evicted registers and the END flush drain before new loads.
- Undefined: pure round-robin, request type ignored.

Test Plan:
- Reset: rst_n=0 with all req_valid=1 -> req_gnt=0, mem_en=0, rsp_valid=0. Release: core0 granted first cycle, mem_en=1 next cycle.
- Single load: NCORES=4, READ_LAT=2, core2 load addr 0x0010, memory holds 0x1234.
  - Grant at cycle 0, mem_en/addr=0x0010 at cycle 1.
  - rsp_valid=4'b0100, rsp_data=0x1234 at cycle 3.
- Fairness: all four cores request continuously from reset -> grant order 0,1,2,3,0,1, one per cycle, mem_en high every cycle from cycle 1.
- Store then load: core1 stores 0x00AB to 0x0005, core3 then loads 0x0005 -> core3 rsp_data=0x00AB; core1 sees no rsp_valid.
- Reset mid-flight: core0 load granted, rst_n pulsed low one cycle later -> no rsp_valid ever issued for that load; busy=0 after reset.
- MEM_ARB_STORE_FIRST_EN defined, pointer=0:
  - Core0 load and core3 store pending -> core3 granted first, then core0.
  - With the macro undefined -> core0 granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NCORES cores, with read-tag tracking.
// Optional: define MEM_ARB_STORE_FIRST_EN to make pending stores win over pending loads.
module mem_port_arbiter #(
  parameter int NCORES   = 4,
  parameter int READ_LAT = 2,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [NCORES-1:0]    req_we,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  output logic [NCORES-1:0]    req_gnt,
  output logic [NCORES-1:0]    rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       idx;
  logic                gnt_any;
  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic [NCORES-1:0]   cand;
  logic [AW-1:0]       addr_a  [NCORES];
  logic [DW-1:0]       wdata_a [NCORES];
  logic [PW-1:0]       cmd_idx;
  logic [READ_LAT-1:0] tag_v;
  logic [PW-1:0]       tag_idx [READ_LAT];
  int unsigned         srch;

  always_comb begin
    for (int unsigned i = 0; i < NCORES; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
    end
  end

  always_comb begin
`ifdef MEM_ARB_STORE_FIRST_EN
    cand = (|(req_valid & req_we)) ? (req_valid & req_we) : req_valid;
`else
    cand = req_valid;
`endif
  end

  // First candidate at or after ptr, wrapping modulo NCORES.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    srch      = 0;
    idx       = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      srch = (k + 32'(ptr)) % NCORES;
      idx  = srch[PW-1:0];
      if (!gnt_any && cand[idx]) begin
        gnt_any   = 1'b1;
        gnt_idx   = idx;
        sel_we    = req_we[idx];
        sel_addr  = addr_a[idx];
        sel_wdata = wdata_a[idx];
      end
    end
    if (!rst_n) gnt_any = 1'b0;
  end

  always_comb begin
    req_gnt = '0;
    if (gnt_any) req_gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_idx   <= '0;
    end else begin
      mem_en <= gnt_any;
      if (gnt_any) begin
        ptr       <= (gnt_idx == PW'(NCORES-1)) ? '0 : gnt_idx + PW'(1);
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        cmd_idx   <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= mem_en & ~mem_we;
      tag_idx[0] <= cmd_idx;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_v[READ_LAT-1]) begin
      rsp_valid[tag_idx[READ_LAT-1]] = 1'b1;
      rsp_data                       = mem_rdata;
    end
  end

  assign busy = mem_en | (|tag_v);

endmodule
